// File: rtl/clk_period_meter_pkg.sv
// clk_period_meter_pkg: FSM states and LCD divided-clock defaults for clk_period_meter.
package clk_period_meter_pkg;
  typedef enum logic {SEEK, MEASURE} state_t;
  localparam int LCD_DIV12_PERIOD = 12;
  localparam int LCD_DIV12_TOL    = 1;
  localparam int LCD_DIV22_PERIOD = 22;
  localparam int LCD_DIV22_TOL    = 1;
endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus delay flop giving synchronized level and rise pulse.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise
);
  logic r_s1, r_s2, r_d;
  always_ff @(posedge i_clk)
    if (!i_rst_n) {r_s1, r_s2, r_d} <= '0;
    else {r_s1, r_s2, r_d} <= {i_sig, r_s1, r_s2};
  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_d;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period/high time of a slow clock, flags lock and stuck.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = LCD_DIV12_PERIOD,
  parameter int TOL        = LCD_DIV12_TOL,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             locked,
  output logic             stuck
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  logic w_rise, w_level, w_in_range, w_timeout;
  logic [CNT_W-1:0] r_per, r_hi, w_period;
  logic [IW-1:0] r_idle;
  logic [GW-1:0] r_good, w_good_inc;
  state_t r_state, w_state_nxt;
  sync_edge_det u_sync (
    .i_clk  (clk_in),
    .i_rst_n(rst_n),
    .i_sig  (sig_in),
    .o_level(w_level),
    .o_rise (w_rise)
  );
  assign w_period   = &r_per ? r_per : r_per + 1'b1;
  assign w_in_range = int'(w_period) >= EXP_PERIOD - TOL && int'(w_period) <= EXP_PERIOD + TOL;
  assign w_good_inc = r_good == GW'(LOCK_CNT) ? r_good : r_good + 1'b1;
  // A rise in the same cycle wins over the timeout.
  assign w_timeout  = r_idle == IW'(TIMEOUT - 2) && !w_rise;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_rise ? MEASURE : w_timeout ? SEEK : r_state;
  end
  always_ff @(posedge clk_in)
    if (!rst_n) r_state <= SEEK;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk_in)
    if (!rst_n) begin
      {meas_valid, locked, stuck} <= '0;
      period_out <= '0;
      high_out   <= '0;
      r_per      <= '0;
      r_hi       <= '0;
      r_idle     <= '0;
      r_good     <= '0;
    end else begin
      meas_valid <= w_rise && r_state == MEASURE;
      r_idle     <= w_rise ? '0 : &r_idle ? r_idle : r_idle + 1'b1;
      if (w_rise) begin
        // The rise cycle is the first (high) cycle of the next period.
        r_per <= '0;
        r_hi  <= CNT_W'(1);
        stuck <= 1'b0;
        if (r_state == MEASURE) begin
          period_out <= w_period;
          high_out   <= r_hi;
          r_good     <= w_in_range ? w_good_inc : '0;
          locked     <= w_in_range ? locked | (w_good_inc == GW'(LOCK_CNT)) : 1'b0;
        end
      end else if (w_timeout) begin
        stuck  <= 1'b1;
        locked <= 1'b0;
        r_good <= '0;
        r_per  <= '0;
        r_hi   <= '0;
      end else if (r_state == MEASURE) begin
        r_per <= &r_per ? r_per : r_per + 1'b1;
        r_hi  <= w_level && !(&r_hi) ? r_hi + 1'b1 : r_hi;
      end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized bench against an event-level model of the period meter.
module tb_clk_period_meter;
  localparam int TIMEOUT = 1024;
  logic clk_in = 1'b0, rst_n = 1'b0, sig_in = 1'b0;
  logic mv16, lk16, st16, mv4, lk4, st4;
  logic [15:0] per16, hi16;
  logic [3:0] per4, hi4;
  int errs = 0, checks = 0;
  bit samp[$];
  int t_rise = 0, t_last = 0, m_good = 0, m_per = 0, m_hi = 0;
  bit meas = 0, m_valid = 0, m_locked = 0, m_stuck = 0;

  clk_period_meter u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .meas_valid(mv16),
    .period_out(per16), .high_out(hi16), .locked(lk16), .stuck(st16)
  );
  clk_period_meter #(.CNT_W(4)) u_dut4 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .meas_valid(mv4),
    .period_out(per4), .high_out(hi4), .locked(lk4), .stuck(st4)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction

  function automatic bit s(input int i);
    return i < 0 ? 1'b0 : samp[i];
  endfunction

  // Model indexed by clock edge; samp holds what the first sync flop captures at each edge.
  task automatic model_edge(input bit sg, input bit rs);
    int n, hi;
    bit in_range;
    samp.push_back(rs & sg);
    n = samp.size() - 1;
    m_valid = 0;
    if (!rs) begin
      meas = 0; m_locked = 0; m_stuck = 0; m_good = 0; m_per = 0; m_hi = 0; t_last = n;
      return;
    end
    if (s(n - 2) && !s(n - 3)) begin
      if (meas) begin
        hi = 0;
        for (int m = t_rise; m < n; m++) hi += int'(s(m - 2));
        m_valid  = 1;
        m_per    = n - t_rise;
        m_hi     = hi;
        in_range = m_per >= 11 && m_per <= 13;
        m_good   = in_range ? mn(m_good + 1, 4) : 0;
        m_locked = in_range && (m_locked || m_good == 4);
      end
      meas = 1; t_rise = n; t_last = n; m_stuck = 0;
    end else if (n - (t_last - 1) == TIMEOUT) begin
      m_stuck = 1; m_locked = 0; m_good = 0; meas = 0;
    end
  endtask

  task automatic step(input bit sg, input bit rs);
    sig_in = sg;
    rst_n  = rs;
    model_edge(sg, rs);
    @(negedge clk_in);
    check("valid", mv16, m_valid);
    check("period", per16, mn(m_per, 65535));
    check("high", hi16, mn(m_hi, 65535));
    check("locked", lk16, m_locked);
    check("stuck", st16, m_stuck);
    check("valid4", mv4, m_valid);
    check("period4", per4, mn(m_per, 15));
    check("high4", hi4, mn(m_hi, 15));
    check("locked4", lk4, m_locked);
    check("stuck4", st4, m_stuck);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      repeat (hi) step(1, 1);
      repeat (lo) step(0, 1);
    end
  endtask

  initial begin
    int h, l;
    repeat (3) step(0, 0);
    wave(6, 6, 8);
    check("lock12", lk16, 1);
    check("per12", per16, 12);
    check("hi12", hi16, 6);
    check("nostuck12", st16, 0);
    wave(7, 8, 1);
    wave(6, 6, 6);
    repeat (1100) step(0, 1);
    check("stuck_hold", st16, 1);
    check("unlock_hold", lk16, 0);
    wave(6, 6, 7);
    repeat (3) step(1, 1);
    repeat (2) step(1, 0);
    wave(6, 6, 6);
    wave(11, 11, 6);
    check("per22", per16, 22);
    check("hi22", hi16, 11);
    check("nolock22", lk16, 0);
    wave(20, 20, 3);
    check("sat_per4", per4, 15);
    check("sat_hi4", hi4, 15);
    check("sat_lock4", lk4, 0);
    repeat (30) begin
      h = $urandom_range(5, 7);
      l = $urandom_range(5, 7);
      wave(h, l, 1);
    end
    repeat (25) begin
      h = $urandom_range(2, 9);
      l = $urandom_range(2, 9);
      wave(h, l, 1);
    end
    repeat (2) step(0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
